// File: rtl/average_calc_pkg.sv
`default_nettype none
// ============================================================================
// average_calc_pkg : shared state encoding and sizing for the averaging FSM
// Rev 1.0
// ============================================================================
package average_calc_pkg;

    localparam int c_avg_state_w = 3;

    typedef enum logic [c_avg_state_w-1:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } avg_state_t;

    // Sample counter width; n is a power of two, so the counter wraps to 0
    // naturally after the last sample.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/average_calc_controller.sv
`default_nettype none
// ============================================================================
// average_calc_controller : sequences init/load/shift strobes for the datapath
// Rev 1.0
// ============================================================================
module average_calc_controller
    import average_calc_pkg::*;
#(
    parameter int n = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic x_valid,
    output logic init_sum,
    output logic init_shift,
    output logic load,
    output logic shift,
    output logic ready,
    output logic busy,
    output logic done
);

    localparam int                 c_cnt_w = cnt_width(n);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(n - 1);

    avg_state_t         r_state;
    avg_state_t         w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_next_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        init_sum     = 1'b0;
        init_shift   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_next_state = ST_INIT;
            end
            ST_INIT: begin
                busy         = 1'b1;
                init_sum     = 1'b1;
                init_shift   = 1'b1;
                w_next_count = '0;
                w_next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                busy = 1'b1;
                load = x_valid;
                if (x_valid) begin
                    w_next_count = r_count + 1'b1;
                    if (r_count == c_last) w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy         = 1'b1;
                shift        = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = start ? ST_INIT : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Cancel overrides every transition; current-cycle strobes stay as decoded.
        if (abort) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
        end
    end

endmodule
`default_nettype wire
